// File: rtl/instruction_encoder_loader.sv
// Program loader for the 8-bit core: packs opcode/Rs/immediate beats into
// instruction words, writes them sequentially into a store, and serves fetch reads.
module instruction_encoder_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_rs,
  input  logic [4:0]        in_imm,
  input  logic              in_use_rs,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              loaded,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ready_q, ready_d;
  logic              loaded_q, loaded_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        rd_q;
  logic [7:0]        word;
  logic              accept;
  logic              at_end;

  logic [7:0] mem [DEPTH];

  // Rs format drops imm[4:3]; imm5 format drops Rs.
  assign word   = in_use_rs ? {in_op, in_rs, in_imm[2:0]} : {in_op, in_imm};
  assign accept = (state_q == LOAD) && ready_q && in_valid;
  assign at_end = (ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          ptr_d    = '0;
          count_d  = '0;
          loaded_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          ptr_d   = ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          // A last beat landing in the final slot is a clean finish, not an overflow.
          if (in_last || at_end) begin
            state_d  = DONE;
            loaded_d = 1'b1;
            ovf_d    = !in_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready lags LOAD entry by a cycle and drops on the edge that leaves LOAD.
    ready_d = (state_q == LOAD) && (state_d == LOAD);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      rd_q     <= mem[rd_addr];
    end
  end

  // Store contents survive reset; a same-address read sees the pre-write word.
  always_ff @(posedge clock) begin
    if (accept) mem[ptr_q] <= word;
  end

  assign in_ready = ready_q;
  assign loaded   = loaded_q;
  assign overflow = ovf_q;
  assign count    = count_q;
  assign rd_data  = rd_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed + randomized bench for instruction_encoder_loader; a full-size and a
// 4-deep instance share the stimulus, the small one exercises overflow.
module tb_instruction_encoder_loader;

  logic       clock = 1'b0, resetn = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic       in_use_rs = 1'b0, in_last = 1'b0;
  logic [2:0] in_op = '0;
  logic [1:0] in_rs = '0;
  logic [4:0] in_imm = '0;
  logic [7:0] rd_addr = '0;

  logic       in_ready, loaded, overflow;
  logic [7:0] rd_data;
  logic [8:0] count;
  logic       s_in_ready, s_loaded, s_overflow;
  logic [7:0] s_rd_data;
  logic [2:0] s_count;

  int pass_cnt = 0;
  int total    = 0;

  logic [7:0] mem_m [256];
  int         mptr = 0;
  logic [7:0] sw [4];

  always #5 clock = ~clock;

  instruction_encoder_loader #(.DEPTH(256), .ADDR_W(8)) u_big (
    .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_imm(in_imm), .in_use_rs(in_use_rs), .in_last(in_last),
    .rd_addr(rd_addr), .rd_data(rd_data), .loaded(loaded), .count(count), .overflow(overflow)
  );

  instruction_encoder_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
    .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_imm(in_imm), .in_use_rs(in_use_rs), .in_last(in_last),
    .rd_addr(rd_addr[1:0]), .rd_data(s_rd_data), .loaded(s_loaded), .count(s_count),
    .overflow(s_overflow)
  );

  // Reference packing from the field layout, by arithmetic.
  function automatic logic [7:0] pack(input int op, input int rs, input int imm, input int use_rs);
    int v;
    if (use_rs != 0) v = op * 32 + rs * 8 + (imm % 8);
    else             v = op * 32 + imm;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input int op, input int rs, input int imm, input int use_rs, input int last);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_op     = op[2:0];
    in_rs     = rs[1:0];
    in_imm    = imm[4:0];
    in_use_rs = use_rs[0];
    in_last   = last[0];
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    mem_m[mptr] = pack(op, rs, imm, use_rs);
    mptr++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mptr = 0;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
    rd_addr = a[7:0];
    @(negedge clock);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int op, rs, imm, ur;
    @(negedge clock);
    @(negedge clock);
    check("rst_ready",    32'(in_ready), 32'd0);
    check("rst_loaded",   32'(loaded),   32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Three fixed beats
    pulse_start();
    check("t1_ready_lag", 32'(in_ready), 32'd0);
    send_beat(5, 2, 3, 1, 0);
    send_beat(2, 0, 22, 0, 0);
    send_beat(7, 1, 31, 1, 1);
    check("t1_count",    32'(count),    32'd3);
    check("t1_loaded",   32'(loaded),   32'd1);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_ready",    32'(in_ready), 32'd0);
    rd_chk("t1_w0", 0, 8'hB3);
    rd_chk("t1_w1", 1, 8'h56);
    rd_chk("t1_w2", 2, 8'hEF);

    // Restart from DONE
    pulse_start();
    check("rs_loaded", 32'(loaded),   32'd0);
    check("rs_count",  32'(count),    32'd0);
    check("rs_ready0", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("rs_ready1", 32'(in_ready), 32'd1);

    // Random beats with valid gaps; invalid cycles carry garbage fields
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        in_op   = 3'($urandom);
        in_imm  = 5'($urandom);
        in_last = 1'($urandom);
        @(negedge clock);
      end
      in_last = 1'b0;
      op  = $urandom_range(7, 0);
      rs  = $urandom_range(3, 0);
      imm = $urandom_range(31, 0);
      ur  = $urandom_range(1, 0);
      send_beat(op, rs, imm, ur, (i == 9) ? 1 : 0);
    end
    check("t2_count",  32'(count),  32'd10);
    check("t2_loaded", 32'(loaded), 32'd1);
    for (int i = 0; i < 10; i++) rd_chk("t2_rd", i, mem_m[i]);

    // Overflow on the 4-deep instance
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      op  = $urandom_range(7, 0);
      rs  = $urandom_range(3, 0);
      imm = $urandom_range(31, 0);
      ur  = $urandom_range(1, 0);
      sw[i] = pack(op, rs, imm, ur);
      send_beat(op, rs, imm, ur, 0);
    end
    check("ov_loaded",   32'(s_loaded),   32'd1);
    check("ov_overflow", 32'(s_overflow), 32'd1);
    check("ov_count",    32'(s_count),    32'd4);
    check("ov_ready",    32'(s_in_ready), 32'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("ov_hold_ready", 32'(s_in_ready), 32'd0);
      check("ov_hold_count", 32'(s_count),    32'd4);
    end
    in_last = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("big_stream_count", 32'(count),  32'd8);
    check("big_stream_done",  32'(loaded), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      @(negedge clock);
      check("ov_rd", 32'(s_rd_data), 32'(sw[i]));
    end

    // Restart clears sticky overflow
    pulse_start();
    check("rs2_loaded",   32'(s_loaded),   32'd0);
    check("rs2_count",    32'(s_count),    32'd0);
    check("rs2_overflow", 32'(s_overflow), 32'd0);
    check("rs2_ready0",   32'(s_in_ready), 32'd0);
    @(negedge clock);
    check("rs2_ready1",   32'(s_in_ready), 32'd1);

    // Read/write collision at address 2
    send_beat(1, 0, 1, 0, 0);
    send_beat(3, 0, 4, 0, 0);
    send_beat(7, 0, 31, 0, 1);
    pulse_start();
    rd_addr = 8'd2;
    send_beat(0, 0, 9, 0, 0);
    check("col_pre", 32'(rd_data), 32'hFF);
    send_beat(4, 0, 2, 0, 0);
    send_beat(2, 0, 26, 0, 1);
    check("col_old", 32'(rd_data), 32'hFF);
    @(negedge clock);
    check("col_new", 32'(rd_data), 32'h5A);

    // Reset in the middle of a load
    pulse_start();
    send_beat(6, 3, 5, 1, 0);
    send_beat(1, 2, 17, 1, 0);
    check("mid_count_pre", 32'(count),    32'd2);
    check("mid_ready_pre", 32'(in_ready), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_ready",    32'(in_ready), 32'd0);
    check("mid_loaded",   32'(loaded),   32'd0);
    check("mid_count",    32'(count),    32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    pulse_start();
    send_beat(3, 1, 12, 0, 1);
    check("mid_re_count",  32'(count),  32'd1);
    check("mid_re_loaded", 32'(loaded), 32'd1);
    rd_chk("mid_rd0", 0, mem_m[0]);
    rd_chk("mid_rd1_kept", 1, mem_m[1]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
